// File: rtl/ahb_mem_slave_p.sv
// ahb_mem_slave_p: parametrised single-port memory slave on the system bus.
// Depth, data width, control-bit positions and wait-state count are parameters.
// Out-of-range accesses return a two-cycle ERROR response. A locked transfer
// survives SEL deassertion; an unlocked one aborts cleanly without side effects.
// Optional build macro: SLAVE_WPROT_EN -- writes at or above PROT_BASE take the
// ERROR path and leave memory unchanged. Without it the whole memory is writable.
module ahb_mem_slave_p #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int MEM_AW      = 11,
    parameter int WRITE_BIT   = 12,
    parameter int TRANS_BIT   = 15,
    parameter int WAIT_CYCLES = 0,
    parameter int PROT_BASE   = 1536
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              MLOCK,
    output logic [DATA_W-1:0] HRDATA,
    output logic [1:0]        HRESP,
    output logic              HREADY
);

    localparam int          DEPTH      = 2 ** MEM_AW;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Any nonzero bit between the word index and the write flag is outside the array.
    function automatic logic range_err_f(input logic [ADDR_W-1:0] a);
        return |a[WRITE_BIT-1:MEM_AW];
    endfunction

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic [MEM_AW-1:0]   addr_r;
    logic                wr_r;
    logic [DATA_W-1:0]   hrdata_r;
    logic [1:0]          hresp_r;
    logic                hready_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                req_s;
    logic                wr_s;
    logic [MEM_AW-1:0]   addr_s;
    logic                range_err_s;
    logic                prot_hit_s;
    logic                abort_s;
    logic                mem_we_s;
    logic                unused_s;

    assign req_s       = SEL && HADDR[TRANS_BIT];
    assign wr_s        = HADDR[WRITE_BIT];
    assign addr_s      = HADDR[MEM_AW-1:0];
    assign range_err_s = range_err_f(HADDR);

    // Losing SEL mid-transfer only matters when the master does not hold the lock.
    assign abort_s     = !SEL && !MLOCK;

`ifdef SLAVE_WPROT_EN
    localparam logic [MEM_AW-1:0] PROT_ADDR = MEM_AW'(PROT_BASE);
    assign prot_hit_s = wr_s && (addr_s >= PROT_ADDR);
    assign unused_s   = ^{1'b0, HADDR};
`else
    assign prot_hit_s = 1'b0;
    assign unused_s   = ^{1'b0, HADDR, (PROT_BASE != 0)};
`endif

    // The array is written only on a committed DATA edge that is neither aborted nor reset.
    assign mem_we_s = (state_r == ST_DATA) && wr_r && !abort_s && !RST;

    assign HRDATA = hrdata_r;
    assign HRESP  = hresp_r;
    assign HREADY = hready_r;

    // Memory array write port; contents deliberately carry no reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= HWDATA;
        end
    end

    // Transfer FSM: capture, wait-state countdown, data phase, error phase and abort.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= '0;
            wr_r     <= 1'b0;
            hrdata_r <= '0;
            hresp_r  <= RESP_OKAY;
            hready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        addr_r   <= addr_s;
                        wr_r     <= wr_s;
                        hready_r <= 1'b0;
                        if (range_err_s || prot_hit_s) begin
                            hresp_r <= RESP_ERROR;
                            cnt_r   <= 4'd0;
                            state_r <= ST_ERR;
                        end else begin
                            hresp_r <= RESP_OKAY;
                            cnt_r   <= WAIT_INIT;
                            state_r <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA;
                        end
                    end else begin
                        hready_r <= 1'b1;
                        hresp_r  <= RESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (abort_s) begin
                        cnt_r    <= 4'd0;
                        hready_r <= 1'b1;
                        hresp_r  <= RESP_OKAY;
                        state_r  <= ST_IDLE;
                    end else if (cnt_r <= 4'd1) begin
                        // Last wait cycle: the following edge is the data phase.
                        cnt_r   <= 4'd0;
                        state_r <= ST_DATA;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DATA: begin
                    if (!abort_s && !wr_r) begin
                        hrdata_r <= mem_r[addr_r];
                    end
                    hready_r <= 1'b1;
                    hresp_r  <= RESP_OKAY;
                    state_r  <= ST_IDLE;
                end
                ST_ERR: begin
                    // Second ERROR cycle: HREADY rises while HRESP stays ERROR.
                    hready_r <= 1'b1;
                    hresp_r  <= RESP_ERROR;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    cnt_r    <= 4'd0;
                    hready_r <= 1'b1;
                    hresp_r  <= RESP_OKAY;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_mem_slave_p.sv
// Self-checking bench for ahb_mem_slave_p: two instances, one with no wait
// states (index 0) and one with three (index 1), sharing clock and reset.
module tb_ahb_mem_slave_p;

    logic              CLK = 1'b0;
    logic              RST;
    logic [1:0]        sel;
    logic [1:0][15:0]  haddr;
    logic [1:0][31:0]  hwdata;
    logic [1:0]        mlock;
    logic [1:0][31:0]  hrdata;
    logic [1:0][1:0]   hresp;
    logic [1:0]        hready;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        int          low;
        logic [1:0]  resp;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    ahb_mem_slave_p #(.WAIT_CYCLES(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .SEL(sel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
        .MLOCK(mlock[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADY(hready[0])
    );

    ahb_mem_slave_p #(.WAIT_CYCLES(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .SEL(sel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
        .MLOCK(mlock[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADY(hready[1])
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transfer on instance d; expected results are queued before driving and
    // popped when HREADY returns high. drop_at = stall cycle at which SEL is removed.
    task automatic run_xfer(input int d, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic lock, input int drop_at, input int exp_low,
                            input logic [1:0] exp_resp, input bit chk_data,
                            input logic [31:0] exp_data, input string name);
        exp_t e;
        int   low;
        bit   resp_ok;
        e.name = name; e.low = exp_low; e.resp = exp_resp;
        e.chk_data = chk_data; e.data = exp_data;
        sb_q.push_back(e);
        sel[d] = 1'b1; haddr[d] = addr; hwdata[d] = wdata; mlock[d] = lock;
        tick();
        haddr[d] = 16'h0000;
        low = 0;
        resp_ok = 1'b1;
        while (hready[d] == 1'b0 && low < 64) begin
            low++;
            if (hresp[d] !== exp_resp) resp_ok = 1'b0;
            if (low == drop_at) sel[d] = 1'b0;
            tick();
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (low !== e.low) begin
            n_err++;
            $display("FAIL %s stall: HREADY low %0d cycles, want %0d", e.name, low, e.low);
        end
        n_cmp++;
        if (resp_ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s stall_resp: HRESP during stall deviated from %b", e.name, e.resp);
        end
        n_cmp++;
        if (hresp[d] !== e.resp) begin
            n_err++;
            $display("FAIL %s done_resp: HRESP %b, want %b", e.name, hresp[d], e.resp);
        end
        if (e.chk_data) begin
            n_cmp++;
            if (hrdata[d] !== e.data) begin
                n_err++;
                $display("FAIL %s data: HRDATA %h, want %h", e.name, hrdata[d], e.data);
            end
        end
        sel[d] = 1'b0; mlock[d] = 1'b0;
        tick();
        n_cmp++;
        if (hready[d] !== 1'b1 || hresp[d] !== 2'b00) begin
            n_err++;
            $display("FAIL %s idle: HREADY %b HRESP %b, want 1 00", e.name, hready[d], hresp[d]);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (hready[d] !== 1'b1 || hresp[d] !== 2'b00 || hrdata[d] !== 32'h0) begin
                n_err++;
                $display("FAIL reset%0d: HREADY %b HRESP %b HRDATA %h, want 1 00 0",
                         d, hready[d], hresp[d], hrdata[d]);
            end
        end
        RST = 1'b0;
        sel = 2'b11;
        haddr[0] = 16'h1005;
        haddr[1] = 16'h1005;
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (hready[d] !== 1'b1 || hresp[d] !== 2'b00) begin
                    n_err++;
                    $display("FAIL notrans%0d: HREADY %b HRESP %b, want 1 00", d, hready[d], hresp[d]);
                end
            end
        end
        sel = 2'b00;
        haddr[0] = 16'h0000;
        haddr[1] = 16'h0000;
        tick();
    endtask

    task automatic test_rw_nowait();
        run_xfer(0, 16'h9005, 32'hDEADBEEF, 1'b0, 0, 1, 2'b00, 1'b1, 32'h0,        "w0_5");
        run_xfer(0, 16'h8005, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'hDEADBEEF, "r0_5");
        run_xfer(0, 16'h9006, 32'h0BADF00D, 1'b0, 0, 1, 2'b00, 1'b1, 32'hDEADBEEF, "w0_6");
        run_xfer(0, 16'h8006, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'h0BADF00D, "r0_6");
        run_xfer(0, 16'h8005, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'hDEADBEEF, "r0_5b");
    endtask

    task automatic test_back_to_back();
        sel[0] = 1'b1;
        haddr[0] = 16'h8005;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (hready[0] !== ((i % 2) == 1) || hresp[0] !== 2'b00) begin
                n_err++;
                $display("FAIL b2b cycle %0d: HREADY %b HRESP %b, want %0d 00", i, hready[0], hresp[0], i % 2);
            end
            if ((i % 2) == 1) begin
                n_cmp++;
                if (hrdata[0] !== 32'hDEADBEEF) begin
                    n_err++;
                    $display("FAIL b2b data %0d: HRDATA %h, want deadbeef", i, hrdata[0]);
                end
            end
        end
        sel[0] = 1'b0;
        haddr[0] = 16'h0000;
        tick();
    endtask

    task automatic test_out_of_range();
        run_xfer(0, 16'h8800, 32'h0,        1'b0, 0, 1, 2'b01, 1'b1, 32'hDEADBEEF, "oor_rd");
        run_xfer(0, 16'h9805, 32'h11111111, 1'b0, 0, 1, 2'b01, 1'b1, 32'hDEADBEEF, "oor_wr");
        run_xfer(0, 16'h8005, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'hDEADBEEF, "oor_chk");
    endtask

    task automatic test_wait_states();
        run_xfer(1, 16'h97FF, 32'hCAFEF00D, 1'b0, 0, 4, 2'b00, 1'b1, 32'h0,        "w3_7ff");
        run_xfer(1, 16'h87FF, 32'h0,        1'b0, 0, 4, 2'b00, 1'b1, 32'hCAFEF00D, "r3_7ff");
        run_xfer(1, 16'h9000, 32'h01234567, 1'b0, 0, 4, 2'b00, 1'b1, 32'hCAFEF00D, "w3_0");
        run_xfer(1, 16'h8000, 32'h0,        1'b0, 0, 4, 2'b00, 1'b1, 32'h01234567, "r3_0");
    endtask

    task automatic test_lock_abort();
        run_xfer(1, 16'h9010, 32'hAAAA5555, 1'b0, 0, 4, 2'b00, 1'b1, 32'h01234567, "pre_wr");
        run_xfer(1, 16'h9010, 32'h12345678, 1'b0, 1, 1, 2'b00, 1'b1, 32'h01234567, "abort_wait");
        run_xfer(1, 16'h8010, 32'h0,        1'b0, 0, 4, 2'b00, 1'b1, 32'hAAAA5555, "abort_chk");
        run_xfer(1, 16'h9010, 32'h12345678, 1'b1, 1, 4, 2'b00, 1'b1, 32'hAAAA5555, "lock_wr");
        run_xfer(1, 16'h8010, 32'h0,        1'b0, 0, 4, 2'b00, 1'b1, 32'h12345678, "lock_chk");
        run_xfer(1, 16'h9010, 32'h0F0F0F0F, 1'b0, 4, 4, 2'b00, 1'b1, 32'h12345678, "abort_data");
        run_xfer(1, 16'h87FF, 32'h0,        1'b0, 2, 2, 2'b00, 1'b1, 32'h12345678, "abort_rd");
        run_xfer(1, 16'h8010, 32'h0,        1'b0, 0, 4, 2'b00, 1'b1, 32'h12345678, "abort_d_chk");
        run_xfer(0, 16'h9005, 32'hFFFFFFFF, 1'b0, 1, 1, 2'b00, 1'b1, 32'hDEADBEEF, "abort_nw");
        run_xfer(0, 16'h8005, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'hDEADBEEF, "abort_nw_chk");
    endtask

    task automatic test_wprot();
`ifdef SLAVE_WPROT_EN
        logic [31:0] old;
        run_xfer(0, 16'h8600, 32'h0,        1'b0, 0, 1, 2'b00, 1'b0, 32'h0, "prot_pre");
        old = hrdata[0];
        run_xfer(0, 16'h9600, 32'hA5A5A5A5, 1'b0, 0, 1, 2'b01, 1'b1, old,          "prot_wr");
        run_xfer(0, 16'h8600, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, old,          "prot_chk");
        run_xfer(0, 16'h95FF, 32'h5A5A5A5A, 1'b0, 0, 1, 2'b00, 1'b1, old,          "unprot_wr");
        run_xfer(0, 16'h85FF, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'h5A5A5A5A, "unprot_chk");
`else
        run_xfer(0, 16'h9600, 32'hA5A5A5A5, 1'b0, 0, 1, 2'b00, 1'b1, 32'hDEADBEEF, "hi_wr");
        run_xfer(0, 16'h8600, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'hA5A5A5A5, "hi_chk");
        run_xfer(0, 16'h95FF, 32'h5A5A5A5A, 1'b0, 0, 1, 2'b00, 1'b1, 32'hA5A5A5A5, "lo_wr");
        run_xfer(0, 16'h85FF, 32'h0,        1'b0, 0, 1, 2'b00, 1'b1, 32'h5A5A5A5A, "lo_chk");
`endif
    endtask

    task automatic test_reset_mid();
        run_xfer(1, 16'h9020, 32'h33333333, 1'b0, 0, 4, 2'b00, 1'b1, 32'h12345678, "mid_pre");
        sel[1] = 1'b1; haddr[1] = 16'h9020; hwdata[1] = 32'h77777777;
        tick();
        haddr[1] = 16'h0000;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sel[1] = 1'b0;
        n_cmp++;
        if (hready[1] !== 1'b1 || hresp[1] !== 2'b00 || hrdata[1] !== 32'h0) begin
            n_err++;
            $display("FAIL mid_rst: HREADY %b HRESP %b HRDATA %h, want 1 00 0", hready[1], hresp[1], hrdata[1]);
        end
        tick();
        run_xfer(1, 16'h8020, 32'h0, 1'b0, 0, 4, 2'b00, 1'b1, 32'h33333333, "mid_chk");
    endtask

    initial begin
        RST = 1'b1;
        sel = 2'b00;
        haddr[0] = 16'h0000; haddr[1] = 16'h0000;
        hwdata[0] = 32'h0; hwdata[1] = 32'h0;
        mlock = 2'b00;
        test_reset();
        test_rw_nowait();
        test_back_to_back();
        test_out_of_range();
        test_wait_states();
        test_lock_abort();
        test_wprot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
